tx_wqe_scheduler: RTL and testbench

- Arbitrates RDMA work requests (WQEs) from NUM_REQ requester queues with round-robin arbitration.
- Assigns each request a per-requester Packet Sequence Number (PSN) and launches it on the TX header-insertion datapath with a one-cycle start_tx pulse and stable header fields.
- Waits for the datapath's tx_done, then returns a completion record to the requester side.
- Sits between the WQE fetch logic and the TX header inserter; only one packet is in flight at a time.

---
 rtl/tx_wqe_scheduler.sv | 171 +++++++++++++++++
 tb/tb_tx_wqe_scheduler.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_wqe_scheduler.sv
// Round-robin RDMA WQE scheduler: per-requester PSNs, one packet in flight, completion return.
// Defining TX_SCHED_WDOG_EN adds a WAIT_DONE watchdog of WDOG_CYCLES cycles (status 2'b10).
module tx_wqe_scheduler #(
  parameter int          NUM_REQ     = 4,
  parameter logic [23:0] PSN_INIT    = 24'h000000,
  parameter int          WDOG_CYCLES = 4096
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*8-1:0]       req_opcode,
  input  logic [NUM_REQ*24-1:0]      req_dest_qp,
  input  logic [NUM_REQ*64-1:0]      req_remote_addr,
  input  logic [NUM_REQ*32-1:0]      req_length,
  output logic                       start_tx,
  output logic [7:0]                 rdma_opcode,
  output logic [23:0]                rdma_psn,
  output logic [23:0]                rdma_dest_qp,
  output logic [63:0]                rdma_remote_addr,
  output logic [31:0]                rdma_length,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic                       cpl_valid,
  input  logic                       cpl_ready,
  output logic [$clog2(NUM_REQ)-1:0] cpl_id,
  output logic [23:0]                cpl_psn,
  output logic [1:0]                 cpl_status
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, CPL} state_e;

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 2) begin : g_bad_params
    $error("tx_wqe_scheduler: unsupported parameter values");
  end

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, grant_q, grantIdx, candIdx;
  logic           grantFound, grantFire, lenZero, doneFire, wdogFire, cplAccept;
  logic [23:0]    psn_q [NUM_REQ];
  logic [7:0]     opcode_q;
  logic [23:0]    rdmaPsn_q, destQp_q;
  logic [63:0]    remoteAddr_q;
  logic [31:0]    length_q;
  logic           startTx_q, cplValid_q;
  logic [1:0]     cplStatus_q;

  // Scan upward from ptr+1 so the last-served requester has lowest priority.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    candIdx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      candIdx = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!grantFound && req_valid[candIdx]) begin
        grantFound = 1'b1;
        grantIdx   = candIdx;
      end
    end
  end

  assign lenZero = (req_length[grantIdx*32 +: 32] == 32'd0);

`ifdef TX_SCHED_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] wdog_q;

  always_ff @(posedge aclk) begin
    if (!aresetn || state_q != WAIT_DONE) wdog_q <= '0;
    else                                  wdog_q <= wdog_q + 1'b1;
  end
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    grantFire = 1'b0;
    doneFire  = 1'b0;
    wdogFire  = 1'b0;
    cplAccept = 1'b0;
    case (state_q)
      IDLE: begin
        if (aresetn && grantFound && !tx_busy) begin
          grantFire           = 1'b1;
          req_ready[grantIdx] = 1'b1;
          state_d             = lenZero ? CPL : LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done) begin
          doneFire = 1'b1;
          state_d  = CPL;
        end
`ifdef TX_SCHED_WDOG_EN
        else if (wdog_q == WDW'(WDOG_CYCLES - 1)) begin
          wdogFire = 1'b1;
          state_d  = CPL;
        end
`endif
      end
      CPL: begin
        if (cplValid_q && cpl_ready) begin
          cplAccept = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ptr_q        <= IDW'(NUM_REQ - 1);
      grant_q      <= '0;
      opcode_q     <= '0;
      rdmaPsn_q    <= '0;
      destQp_q     <= '0;
      remoteAddr_q <= '0;
      length_q     <= '0;
      startTx_q    <= 1'b0;
      cplValid_q   <= 1'b0;
      cplStatus_q  <= 2'b00;
      for (int i = 0; i < NUM_REQ; i++) psn_q[i] <= PSN_INIT;
    end else begin
      startTx_q <= grantFire && !lenZero;
      if (grantFire) begin
        grant_q      <= grantIdx;
        opcode_q     <= req_opcode[grantIdx*8 +: 8];
        destQp_q     <= req_dest_qp[grantIdx*24 +: 24];
        remoteAddr_q <= req_remote_addr[grantIdx*64 +: 64];
        length_q     <= req_length[grantIdx*32 +: 32];
        rdmaPsn_q    <= psn_q[grantIdx];
      end
      if (doneFire) psn_q[grant_q] <= psn_q[grant_q] + 24'd1;
      // Only a successful transmit advances the PSN; rejects and timeouts leave it alone.
      if (grantFire && lenZero) begin
        cplValid_q  <= 1'b1;
        cplStatus_q <= 2'b01;
      end else if (doneFire) begin
        cplValid_q  <= 1'b1;
        cplStatus_q <= 2'b00;
      end else if (wdogFire) begin
        cplValid_q  <= 1'b1;
        cplStatus_q <= 2'b10;
      end else if (cplAccept) begin
        cplValid_q  <= 1'b0;
        ptr_q       <= grant_q;
      end
    end
  end

  assign start_tx         = startTx_q;
  assign rdma_opcode      = opcode_q;
  assign rdma_psn         = rdmaPsn_q;
  assign rdma_dest_qp     = destQp_q;
  assign rdma_remote_addr = remoteAddr_q;
  assign rdma_length      = length_q;
  assign cpl_valid        = cplValid_q;
  assign cpl_id           = grant_q;
  assign cpl_psn          = rdmaPsn_q;
  assign cpl_status       = cplStatus_q;

endmodule

// File: tb/tb_tx_wqe_scheduler.sv
// Directed self-checking bench for tx_wqe_scheduler; a second instance starts PSNs at FFFFFE.
// The watchdog scenario is compiled only when TX_SCHED_WDOG_EN is defined.
module tb_tx_wqe_scheduler;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [3:0]   reqValid;
  logic [31:0]  reqOpcode;
  logic [95:0]  reqDestQp;
  logic [255:0] reqRemoteAddr;
  logic [127:0] reqLength;
  logic         txBusy, txDone, cplReady;

  logic [3:0]  reqReady, wReqReady;
  logic        startTx, wStartTx, cplValid, wCplValid;
  logic [7:0]  rdmaOpcode, wRdmaOpcode;
  logic [23:0] rdmaPsn, wRdmaPsn, rdmaDestQp, wRdmaDestQp, cplPsn, wCplPsn;
  logic [63:0] rdmaRemoteAddr, wRdmaRemoteAddr;
  logic [31:0] rdmaLength, wRdmaLength;
  logic [1:0]  cplId, wCplId, cplStatus, wCplStatus;

  int testsRun = 0;
  int testsFailed = 0;

  tx_wqe_scheduler #(.NUM_REQ(4), .PSN_INIT(24'h000000), .WDOG_CYCLES(8)) dut (
    .aclk(aclk), .aresetn(aresetn), .req_valid(reqValid), .req_ready(reqReady),
    .req_opcode(reqOpcode), .req_dest_qp(reqDestQp), .req_remote_addr(reqRemoteAddr),
    .req_length(reqLength), .start_tx(startTx), .rdma_opcode(rdmaOpcode), .rdma_psn(rdmaPsn),
    .rdma_dest_qp(rdmaDestQp), .rdma_remote_addr(rdmaRemoteAddr), .rdma_length(rdmaLength),
    .tx_busy(txBusy), .tx_done(txDone), .cpl_valid(cplValid), .cpl_ready(cplReady),
    .cpl_id(cplId), .cpl_psn(cplPsn), .cpl_status(cplStatus));

  tx_wqe_scheduler #(.NUM_REQ(4), .PSN_INIT(24'hFFFFFE), .WDOG_CYCLES(8)) dutWrap (
    .aclk(aclk), .aresetn(aresetn), .req_valid(reqValid), .req_ready(wReqReady),
    .req_opcode(reqOpcode), .req_dest_qp(reqDestQp), .req_remote_addr(reqRemoteAddr),
    .req_length(reqLength), .start_tx(wStartTx), .rdma_opcode(wRdmaOpcode), .rdma_psn(wRdmaPsn),
    .rdma_dest_qp(wRdmaDestQp), .rdma_remote_addr(wRdmaRemoteAddr), .rdma_length(wRdmaLength),
    .tx_busy(txBusy), .tx_done(txDone), .cpl_valid(wCplValid), .cpl_ready(cplReady),
    .cpl_id(wCplId), .cpl_psn(wCplPsn), .cpl_status(wCplStatus));

  initial forever #5 aclk = ~aclk;

  // Inputs change 2ns after the rising edge; checks happen 1ns later, well before the next edge.
  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic setReq(input int idx, input logic [7:0] op, input logic [23:0] qp,
                        input logic [63:0] addr, input logic [31:0] len);
    reqOpcode[idx*8 +: 8]       = op;
    reqDestQp[idx*24 +: 24]     = qp;
    reqRemoteAddr[idx*64 +: 64] = addr;
    reqLength[idx*32 +: 32]     = len;
    reqValid[idx]               = 1'b1;
  endtask

  task automatic doReset();
    aresetn  = 1'b0;
    reqValid = '0;
    txBusy   = 1'b0;
    txDone   = 1'b0;
    cplReady = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();
  endtask

  // Called in the LAUNCH cycle; completes the packet and accepts its completion.
  task automatic finishFromLaunch();
    tick();
    txDone = 1'b1;
    tick();
    txDone   = 1'b0;
    cplReady = 1'b1;
    tick();
    cplReady = 1'b0;
  endtask

  task automatic runWqe(input int idx, input logic [31:0] len);
    setReq(idx, 8'h01, 24'h0, 64'h0, len);
    tick();
    reqValid[idx] = 1'b0;
    finishFromLaunch();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    for (int i = 0; i < 4; i++) setReq(i, 8'hFF, 24'hFFFFFF, 64'h1, 32'd5);
    txBusy   = 1'b0;
    txDone   = 1'b1;
    cplReady = 1'b1;
    tick();
    tick();
    #1;
    testsRun++;
    if (reqReady !== 4'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_req_ready: got %b expected 0000", reqReady);
    end
    testsRun++;
    if ({startTx, rdmaOpcode, rdmaPsn, rdmaDestQp, rdmaRemoteAddr, rdmaLength,
         cplValid, cplId, cplPsn, cplStatus} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: start=%b op=%h psn=%h qp=%h addr=%h len=%h cv=%b id=%h cpsn=%h st=%b expected all 0",
               startTx, rdmaOpcode, rdmaPsn, rdmaDestQp, rdmaRemoteAddr, rdmaLength,
               cplValid, cplId, cplPsn, cplStatus);
    end
    testsRun++;
    if ({wReqReady, wStartTx, wRdmaOpcode, wRdmaPsn, wRdmaDestQp, wRdmaRemoteAddr,
         wRdmaLength, wCplValid, wCplId, wCplPsn, wCplStatus} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs_wrap: psn=%h cv=%b expected all outputs 0", wRdmaPsn, wCplValid);
    end
    reqValid = '0;
    txDone   = 1'b0;
    cplReady = 1'b0;
    aresetn  = 1'b1;
    tick();
  endtask

  task automatic test_single();
    doReset();
    setReq(2, 8'h0A, 24'h123456, 64'hDEAD_BEEF_0000_1000, 32'd16);
    #1;
    testsRun++;
    if (reqReady !== 4'b0100) begin
      testsFailed++;
      $display("[TB] FAIL single_ready: got %b expected 0100", reqReady);
    end
    tick();
    reqValid = '0;
    #1;
    testsRun++;
    if ({startTx, rdmaPsn, rdmaOpcode, rdmaLength, rdmaDestQp, rdmaRemoteAddr, reqReady} !==
        {1'b1, 24'd0, 8'h0A, 32'd16, 24'h123456, 64'hDEAD_BEEF_0000_1000, 4'b0}) begin
      testsFailed++;
      $display("[TB] FAIL single_launch: start=%b psn=%h op=%h len=%0d qp=%h addr=%h rdy=%b expected 1/0/0a/16/123456/deadbeef00001000/0000",
               startTx, rdmaPsn, rdmaOpcode, rdmaLength, rdmaDestQp, rdmaRemoteAddr, reqReady);
    end
    tick();
    #1;
    testsRun++;
    if (startTx !== 1'b0 || cplValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_wait: start=%b cpl_valid=%b expected 0/0", startTx, cplValid);
    end
    txDone = 1'b1;
    tick();
    txDone   = 1'b0;
    cplReady = 1'b1;
    #1;
    testsRun++;
    if ({cplValid, cplId, cplPsn, cplStatus} !== {1'b1, 2'd2, 24'd0, 2'b00}) begin
      testsFailed++;
      $display("[TB] FAIL single_cpl: valid=%b id=%0d psn=%h status=%b expected 1/2/000000/00",
               cplValid, cplId, cplPsn, cplStatus);
    end
    tick();
    cplReady = 1'b0;
    #1;
    testsRun++;
    if (cplValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_cpl_drop: cpl_valid=%b expected 0", cplValid);
    end
    setReq(2, 8'h0A, 24'h123456, 64'hDEAD_BEEF_0000_1000, 32'd16);
    tick();
    reqValid = '0;
    #1;
    testsRun++;
    if (startTx !== 1'b1 || rdmaPsn !== 24'd1) begin
      testsFailed++;
      $display("[TB] FAIL single_second_psn: start=%b psn=%h expected 1/000001", startTx, rdmaPsn);
    end
    finishFromLaunch();
  endtask

  task automatic test_fairness();
    int expIdx;
    logic [23:0] expPsn;
    doReset();
    for (int i = 0; i < 4; i++) setReq(i, 8'h20 + 8'(i), 24'(i), 64'(i), 32'(i + 1));
    cplReady = 1'b1;
    for (int n = 0; n < 6; n++) begin
      expIdx = n % 4;
      expPsn = 24'(n / 4);
      #1;
      testsRun++;
      if (reqReady !== 4'(1 << expIdx)) begin
        testsFailed++;
        $display("[TB] FAIL fair_grant_%0d: got %b expected %b", n, reqReady, 4'(1 << expIdx));
      end
      tick();
      #1;
      testsRun++;
      if ({startTx, rdmaPsn, rdmaLength} !== {1'b1, expPsn, 32'(expIdx + 1)}) begin
        testsFailed++;
        $display("[TB] FAIL fair_launch_%0d: start=%b psn=%h len=%0d expected 1/%h/%0d",
                 n, startTx, rdmaPsn, rdmaLength, expPsn, expIdx + 1);
      end
      tick();
      txDone = 1'b1;
      tick();
      txDone = 1'b0;
      #1;
      testsRun++;
      if ({cplValid, cplId, cplPsn} !== {1'b1, 2'(expIdx), expPsn}) begin
        testsFailed++;
        $display("[TB] FAIL fair_cpl_%0d: valid=%b id=%0d psn=%h expected 1/%0d/%h",
                 n, cplValid, cplId, cplPsn, expIdx, expPsn);
      end
      tick();
    end
    reqValid = '0;
    cplReady = 1'b0;
    tick();
  endtask

  task automatic test_zero_length();
    doReset();
    setReq(1, 8'h11, 24'h000111, 64'h0, 32'd0);
    #1;
    testsRun++;
    if (reqReady !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL zero_ready: got %b expected 0010", reqReady);
    end
    tick();
    reqValid = '0;
    cplReady = 1'b1;
    #1;
    testsRun++;
    if ({startTx, cplValid, cplId, cplPsn, cplStatus} !== {1'b0, 1'b1, 2'd1, 24'd0, 2'b01}) begin
      testsFailed++;
      $display("[TB] FAIL zero_cpl: start=%b valid=%b id=%0d psn=%h status=%b expected 0/1/1/000000/01",
               startTx, cplValid, cplId, cplPsn, cplStatus);
    end
    tick();
    cplReady = 1'b0;
    #1;
    testsRun++;
    if (startTx !== 1'b0 || cplValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL zero_no_launch: start=%b cpl_valid=%b expected 0/0", startTx, cplValid);
    end
    setReq(1, 8'h11, 24'h000111, 64'h0, 32'd8);
    tick();
    reqValid = '0;
    #1;
    testsRun++;
    if (startTx !== 1'b1 || rdmaPsn !== 24'd0) begin
      testsFailed++;
      $display("[TB] FAIL zero_psn_kept: start=%b psn=%h expected 1/000000", startTx, rdmaPsn);
    end
    finishFromLaunch();
  endtask

  task automatic test_busy_done();
    int bad;
    int holdCycles;
`ifdef TX_SCHED_WDOG_EN
    holdCycles = 3;
`else
    holdCycles = 20;
`endif
    doReset();
    txBusy = 1'b1;
    setReq(1, 8'h33, 24'h000033, 64'h33, 32'd2);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      txDone = 1'b1;
      #1;
      if (reqReady !== 4'b0 || startTx !== 1'b0) bad++;
      tick();
    end
    txDone = 1'b0;
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL busy_blocks_grant: %0d cycles with a grant or launch, expected 0", bad);
    end
    txBusy = 1'b0;
    #1;
    testsRun++;
    if (reqReady !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL busy_release_ready: got %b expected 0010", reqReady);
    end
    tick();
    reqValid = '0;
    txDone   = 1'b1;
    tick();
    txDone = 1'b0;
    bad    = 0;
    for (int k = 0; k < holdCycles; k++) begin
      #1;
      if (cplValid !== 1'b0) bad++;
      tick();
    end
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL done_wait_hold: %0d cycles with cpl_valid, expected 0", bad);
    end
    txDone = 1'b1;
    tick();
    txDone   = 1'b0;
    cplReady = 1'b1;
    #1;
    testsRun++;
    if ({cplValid, cplId, cplPsn, cplStatus} !== {1'b1, 2'd1, 24'd0, 2'b00}) begin
      testsFailed++;
      $display("[TB] FAIL done_cpl: valid=%b id=%0d psn=%h status=%b expected 1/1/000000/00",
               cplValid, cplId, cplPsn, cplStatus);
    end
    tick();
    cplReady = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad;
    doReset();
    setReq(0, 8'h44, 24'hABCDEF, 64'h4444, 32'd4);
    setReq(3, 8'h77, 24'h777777, 64'h7777, 32'd4);
    #1;
    testsRun++;
    if (reqReady !== 4'b0001) begin
      testsFailed++;
      $display("[TB] FAIL bp_first_grant: got %b expected 0001", reqReady);
    end
    tick();
    reqValid[0] = 1'b0;
    tick();
    txDone = 1'b1;
    tick();
    txDone = 1'b0;
    bad    = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if ({cplValid, cplId, cplPsn, cplStatus, reqReady, startTx} !==
          {1'b1, 2'd0, 24'd0, 2'b00, 4'b0, 1'b0}) bad++;
      tick();
    end
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL bp_hold: %0d cycles with cpl_* changed or a new grant/launch, expected 0", bad);
    end
    cplReady = 1'b1;
    tick();
    cplReady = 1'b0;
    #1;
    testsRun++;
    if (cplValid !== 1'b0 || reqReady !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL bp_release: cpl_valid=%b ready=%b expected 0/1000", cplValid, reqReady);
    end
    tick();
    reqValid = '0;
    #1;
    testsRun++;
    if (startTx !== 1'b1 || rdmaDestQp !== 24'h777777) begin
      testsFailed++;
      $display("[TB] FAIL bp_next_launch: start=%b qp=%h expected 1/777777", startTx, rdmaDestQp);
    end
    finishFromLaunch();
  endtask

  task automatic test_psn_wrap();
    logic [23:0] expPsn;
    doReset();
    for (int n = 0; n < 3; n++) begin
      expPsn = 24'hFFFFFE + 24'(n);
      setReq(0, 8'h55, 24'h000055, 64'h55, 32'd4);
      tick();
      reqValid = '0;
      #1;
      testsRun++;
      if (wStartTx !== 1'b1 || wRdmaPsn !== expPsn) begin
        testsFailed++;
        $display("[TB] FAIL wrap_launch_%0d: start=%b psn=%h expected 1/%h", n, wStartTx, wRdmaPsn, expPsn);
      end
      tick();
      txDone = 1'b1;
      tick();
      txDone   = 1'b0;
      cplReady = 1'b1;
      #1;
      testsRun++;
      if (wCplValid !== 1'b1 || wCplPsn !== expPsn) begin
        testsFailed++;
        $display("[TB] FAIL wrap_cpl_%0d: valid=%b psn=%h expected 1/%h", n, wCplValid, wCplPsn, expPsn);
      end
      tick();
      cplReady = 1'b0;
    end
  endtask

  task automatic test_midreset();
    doReset();
    runWqe(0, 32'd4);
    setReq(0, 8'h66, 24'h000066, 64'h66, 32'd4);
    tick();
    reqValid = '0;
    tick();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    #1;
    testsRun++;
    if (cplValid !== 1'b0 || startTx !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_drop: cpl_valid=%b start=%b expected 0/0", cplValid, startTx);
    end
    setReq(0, 8'h66, 24'h000066, 64'h66, 32'd4);
    tick();
    reqValid = '0;
    #1;
    testsRun++;
    if (startTx !== 1'b1 || rdmaPsn !== 24'd0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_psn: start=%b psn=%h expected 1/000000", startTx, rdmaPsn);
    end
    finishFromLaunch();
  endtask

`ifdef TX_SCHED_WDOG_EN
  task automatic test_watchdog();
    int bad;
    doReset();
    setReq(2, 8'h88, 24'h000088, 64'h88, 32'd4);
    tick();
    reqValid = '0;
    tick();
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (cplValid !== 1'b0) bad++;
      tick();
    end
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL wdog_early: %0d early completions, expected 0", bad);
    end
    cplReady = 1'b1;
    #1;
    testsRun++;
    if ({cplValid, cplId, cplPsn, cplStatus} !== {1'b1, 2'd2, 24'd0, 2'b10}) begin
      testsFailed++;
      $display("[TB] FAIL wdog_timeout: valid=%b id=%0d psn=%h status=%b expected 1/2/000000/10",
               cplValid, cplId, cplPsn, cplStatus);
    end
    tick();
    cplReady = 1'b0;
    setReq(2, 8'h88, 24'h000088, 64'h88, 32'd4);
    tick();
    reqValid = '0;
    #1;
    testsRun++;
    if (rdmaPsn !== 24'd0) begin
      testsFailed++;
      $display("[TB] FAIL wdog_psn_kept: psn=%h expected 000000", rdmaPsn);
    end
    tick();
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) txDone = 1'b1;
      tick();
    end
    txDone   = 1'b0;
    cplReady = 1'b1;
    #1;
    testsRun++;
    if ({cplValid, cplPsn, cplStatus} !== {1'b1, 24'd0, 2'b00}) begin
      testsFailed++;
      $display("[TB] FAIL wdog_done_wins: valid=%b psn=%h status=%b expected 1/000000/00",
               cplValid, cplPsn, cplStatus);
    end
    tick();
    cplReady = 1'b0;
    setReq(2, 8'h88, 24'h000088, 64'h88, 32'd4);
    tick();
    reqValid = '0;
    #1;
    testsRun++;
    if (rdmaPsn !== 24'd1) begin
      testsFailed++;
      $display("[TB] FAIL wdog_psn_after_done: psn=%h expected 000001", rdmaPsn);
    end
    finishFromLaunch();
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    aresetn       = 1'b0;
    reqValid      = '0;
    reqOpcode     = '0;
    reqDestQp     = '0;
    reqRemoteAddr = '0;
    reqLength     = '0;
    txBusy        = 1'b0;
    txDone        = 1'b0;
    cplReady      = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_zero_length();
    test_busy_done();
    test_backpressure();
    test_psn_wrap();
    test_midreset();
`ifdef TX_SCHED_WDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
